// File: rtl/sent_tx_frame_ctrl_if.sv
// Frame handshake and pulse-generator command bundle for sent_tx_frame_ctrl.
// master = frame source / pulse generator side, slave = the sequencer.
interface sent_tx_frame_ctrl_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  frame_status;
  logic [23:0] frame_data;
  logic        pulse_done;
  logic [3:0]  data_nibble;
  logic        sync;
  logic        pulse;
  logic        pause;
  logic        idle;
  logic        frame_done;
  logic        busy;

  modport master (
    output frame_valid, frame_status, frame_data, pulse_done,
    input  frame_ready, data_nibble, sync, pulse, pause, idle, frame_done, busy
  );

  modport slave (
    input  frame_valid, frame_status, frame_data, pulse_done,
    output frame_ready, data_nibble, sync, pulse, pause, idle, frame_done, busy
  );
endinterface

// File: rtl/sent_tx_frame_ctrl.sv
// SENT transmit frame sequencer: buffers a frame, computes CRC-4, steps the pulse generator.
// Define SENT_TX_PAUSE_EN to append a pause pulse after the CRC nibble.
module sent_tx_frame_ctrl #(
  parameter int unsigned NUM_DATA_NIBBLES = 6,
  parameter logic [3:0]  CRC_SEED         = 4'b0101
) (
  input logic                 ticks,
  input logic                 reset_tx,
  sent_tx_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SYNC, STATUS, DATA, CRC, PAUSE} state_t;

  // Command register bits: {sync, pulse, pause, idle}
  localparam logic [3:0] CMD_SYNC  = 4'b1000;
  localparam logic [3:0] CMD_PULSE = 4'b0100;
  localparam logic [3:0] CMD_PAUSE = 4'b0010;
  localparam logic [3:0] CMD_IDLE  = 4'b0001;

  state_t      state;
  logic [3:0]  cmd;
  logic [3:0]  buf_status;
  logic [23:0] buf_data;
  logic [3:0]  work_status;
  logic [23:0] work_data;
  logic [3:0]  crc;
  logic [2:0]  idx;
  logic        eof;
  logic        load;
  logic        start;
  logic [3:0]  crc_upd;

  function automatic logic [3:0] crc_t(input logic [3:0] c);
    case (c)
      4'h0: crc_t = 4'd0;   4'h1: crc_t = 4'd13;
      4'h2: crc_t = 4'd7;   4'h3: crc_t = 4'd10;
      4'h4: crc_t = 4'd14;  4'h5: crc_t = 4'd3;
      4'h6: crc_t = 4'd9;   4'h7: crc_t = 4'd4;
      4'h8: crc_t = 4'd1;   4'h9: crc_t = 4'd12;
      4'hA: crc_t = 4'd6;   4'hB: crc_t = 4'd11;
      4'hC: crc_t = 4'd15;  4'hD: crc_t = 4'd2;
      4'hE: crc_t = 4'd8;   default: crc_t = 4'd5;
    endcase
  endfunction

  assign bus.sync  = cmd[3];
  assign bus.pulse = cmd[2];
  assign bus.pause = cmd[1];
  assign bus.idle  = cmd[0];

  always_comb begin
`ifdef SENT_TX_PAUSE_EN
    eof = bus.pulse_done && (state == PAUSE);
`else
    eof = bus.pulse_done && (state == CRC);
`endif
    load    = bus.frame_valid && bus.frame_ready;
    // Buffer drains into the working register from IDLE or straight out of end-of-frame.
    start   = !bus.frame_ready && ((state == IDLE) || eof);
    crc_upd = work_data[23:20] ^ crc_t(crc);
  end

  always_ff @(posedge ticks) begin
    if (!reset_tx) begin
      state           <= IDLE;
      cmd             <= CMD_IDLE;
      bus.frame_ready <= 1'b1;
      bus.data_nibble <= '0;
      bus.frame_done  <= 1'b0;
      bus.busy        <= 1'b0;
      buf_status      <= '0;
      buf_data        <= '0;
      work_status     <= '0;
      work_data       <= '0;
      crc             <= '0;
      idx             <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      if (load) begin
        buf_status <= bus.frame_status;
        buf_data   <= bus.frame_data;
      end
      // A load in the same tick as a drain keeps the buffer full.
      bus.frame_ready <= !(load || (!bus.frame_ready && !start));

      if (start) begin
        state           <= SYNC;
        cmd             <= CMD_SYNC;
        bus.data_nibble <= '0;
        bus.busy        <= 1'b1;
        bus.frame_done  <= eof;
        work_status     <= buf_status;
        work_data       <= buf_data;
        crc             <= CRC_SEED;
        idx             <= '0;
      end else if (eof) begin
        state           <= IDLE;
        cmd             <= CMD_IDLE;
        bus.data_nibble <= '0;
        bus.busy        <= 1'b0;
        bus.frame_done  <= 1'b1;
      end else if (bus.pulse_done) begin
        case (state)
          SYNC: begin
            state           <= STATUS;
            cmd             <= CMD_PULSE;
            bus.data_nibble <= work_status;
          end
          STATUS: begin
            state           <= DATA;
            bus.data_nibble <= work_data[23:20];
          end
          DATA: begin
            crc <= crc_upd;
            if (idx < 3'(NUM_DATA_NIBBLES - 1)) begin
              idx             <= idx + 3'd1;
              work_data       <= work_data << 4;
              bus.data_nibble <= work_data[19:16];
            end else begin
              state           <= CRC;
              bus.data_nibble <= crc_t(crc_upd);
            end
          end
`ifdef SENT_TX_PAUSE_EN
          CRC: begin
            state           <= PAUSE;
            cmd             <= CMD_PAUSE;
            bus.data_nibble <= '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// Scoreboard bench for sent_tx_frame_ctrl: stimulus queues expected pulse commands,
// a monitor pops and compares each new command and frame_done strobe.
module tb_sent_tx_frame_ctrl;

  logic ticks = 1'b0;
  logic reset_tx;
  sent_tx_frame_ctrl_if bus ();

  sent_tx_frame_ctrl #(.NUM_DATA_NIBBLES(6), .CRC_SEED(4'b0101)) dut (
    .ticks    (ticks),
    .reset_tx (reset_tx),
    .bus      (bus.slave)
  );

  always #5 ticks = ~ticks;

  localparam logic [1:0] EV_SYNC = 2'd0, EV_PULSE = 2'd1, EV_PAUSE = 2'd2, EV_DONE = 2'd3;
`ifdef SENT_TX_PAUSE_EN
  localparam int EV_PER_FRAME = 11;
`else
  localparam int EV_PER_FRAME = 10;
`endif

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] nib;
  } ev_t;

  ev_t  sb[$];
  int   total = 0;
  int   bad   = 0;
  logic pd_q  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input logic [1:0] k, input logic [3:0] n);
    ev_t e;
    e.kind = k;
    e.nib  = n;
    sb.push_back(e);
  endfunction

  // Expected CRC is hand-computed and supplied with each vector.
  function automatic void push_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] crc);
    push_ev(EV_SYNC, 4'h0);
    push_ev(EV_PULSE, st);
    for (int i = 0; i < 6; i++) push_ev(EV_PULSE, d[23-4*i -: 4]);
    push_ev(EV_PULSE, crc);
`ifdef SENT_TX_PAUSE_EN
    push_ev(EV_PAUSE, 4'h0);
`endif
    push_ev(EV_DONE, 4'h0);
  endfunction

  always @(posedge ticks) pd_q <= bus.pulse_done;

  // Pulse generator model: sync 56 ticks, nibble 12+value, pause 20.
  initial begin
    int cnt;
    cnt = 0;
    bus.pulse_done = 1'b0;
    forever begin
      @(negedge ticks);
      bus.pulse_done = 1'b0;
      if (!reset_tx || bus.idle) begin
        cnt = 0;
      end else begin
        if (cnt == 0) cnt = bus.sync ? 56 : (bus.pause ? 20 : 12 + int'(bus.data_nibble));
        cnt--;
        if (cnt == 0) bus.pulse_done = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    logic       prev_active;
    logic [1:0] act_kind;
    ev_t        e;
    prev_active = 1'b0;
    forever begin
      @(negedge ticks);
      if (!reset_tx) begin
        prev_active = 1'b0;
      end else begin
        check("cmd_onehot", 32'(bus.sync) + 32'(bus.pulse) + 32'(bus.pause) + 32'(bus.idle), 1);
        if (bus.frame_done) begin
          if (sb.size() == 0) check("unexpected_frame_done", 1, 0);
          else begin
            e = sb.pop_front();
            check("frame_done_order", 32'(e.kind), 32'(EV_DONE));
          end
        end
        if (!bus.idle && (!prev_active || pd_q)) begin
          act_kind = bus.sync ? EV_SYNC : (bus.pulse ? EV_PULSE : EV_PAUSE);
          if (sb.size() == 0) check("unexpected_command", 1, 0);
          else begin
            e = sb.pop_front();
            check("cmd_kind", 32'(act_kind), 32'(e.kind));
            check("cmd_nibble", 32'(bus.data_nibble), 32'(e.nib));
          end
        end
        prev_active = !bus.idle;
      end
    end
  end

  task automatic tick();
    @(posedge ticks);
    #1;
  endtask

  task automatic send(input logic [3:0] st, input logic [23:0] d, input logic [3:0] crc);
    int n;
    bus.frame_status = st;
    bus.frame_data   = d;
    bus.frame_valid  = 1'b1;
    n = 0;
    while (!bus.frame_ready && n < 3000) begin
      tick();
      n++;
    end
    check("send_ready_timeout", 32'(n >= 3000), 0);
    tick();
    bus.frame_valid = 1'b0;
    push_frame(st, d, crc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.idle) && n < 4000) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n >= 4000), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_idle"}, 32'(bus.idle), 1);
    check({tag, "_frame_ready"}, 32'(bus.frame_ready), 1);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    check({tag, "_cmds"}, {29'd0, bus.sync, bus.pulse, bus.pause}, 0);
    check({tag, "_data_nibble"}, 32'(bus.data_nibble), 0);
  endtask

  initial begin
    int n;
    reset_tx         = 1'b0;
    bus.frame_valid  = 1'b0;
    bus.frame_status = '0;
    bus.frame_data   = '0;
    repeat (3) tick();
    check_reset_state("reset");
    reset_tx = 1'b1;
    tick();

    // All-zero frame, with handshake-to-sync latency
    send(4'h0, 24'h000000, 4'h5);
    check("lat_no_sync_yet", 32'(bus.sync), 0);
    check("lat_buffer_full", 32'(bus.frame_ready), 0);
    tick();
    check("lat_sync", 32'(bus.sync), 1);
    check("lat_busy", 32'(bus.busy), 1);
    check("lat_ready_back", 32'(bus.frame_ready), 1);
    wait_drain();
    check("f1_end_busy", 32'(bus.busy), 0);

    send(4'hA, 24'h123456, 4'h2);
    wait_drain();

    // Back-to-back: second frame offered while the first is in DATA
    send(4'hA, 24'h123456, 4'h2);
    n = 0;
    while (sb.size() > EV_PER_FRAME - 4 && n < 3000) begin
      tick();
      n++;
    end
    check("b2b_data_timeout", 32'(n >= 3000), 0);
    check("b2b_ready_before", 32'(bus.frame_ready), 1);
    send(4'h5, 24'h111111, 4'hF);
    check("b2b_ready_dropped", 32'(bus.frame_ready), 0);
    n = 0;
    while (!bus.frame_done && n < 3000) begin
      tick();
      n++;
    end
    check("b2b_done_timeout", 32'(n >= 3000), 0);
    check("b2b_sync_no_gap", 32'(bus.sync), 1);
    check("b2b_no_idle", 32'(bus.idle), 0);
    check("b2b_ready_again", 32'(bus.frame_ready), 1);
    wait_drain();

    // Reset during data nibble 3
    send(4'hA, 24'h123456, 4'h2);
    n = 0;
    while (sb.size() > EV_PER_FRAME - 6 && n < 3000) begin
      tick();
      n++;
    end
    check("rst_mid_timeout", 32'(n >= 3000), 0);
    check("rst_mid_nibble3", 32'(bus.data_nibble), 4);
    reset_tx = 1'b0;
    sb.delete();
    tick();
    check_reset_state("rst_mid");
    reset_tx = 1'b1;
    tick();
    send(4'h3, 24'h000000, 4'h5);
    wait_drain();
    check("final_idle", 32'(bus.idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sent_tx_frame_ctrl.md
Name: sent_tx_frame_ctrl

Overview:
- Upstream sequencer for the SENT transmit pulse generator.
- Accepts a frame (status nibble plus data nibbles) over a valid/ready handshake and computes the SENT CRC-4.
- Drives the pulse generator's command lines in order: sync, status, data nibbles, CRC, optional pause.
- Advances one step on each `pulse_done`. A one-entry holding buffer permits back-to-back frames.

Parameters:
- NUM_DATA_NIBBLES, 6, data nibbles per frame; legal 1..6.
- CRC_SEED, 4'b0101, CRC-4 initial value.

Ports:
- ticks  input  1  tick clock, all logic on rising edge.
- reset_tx  input  1  synchronous, active-low reset.
- frame_valid  input  1  frame offered.
- frame_ready  output  1  holding buffer empty; frame accepted when frame_valid & frame_ready.
- frame_status  input  4  status/comm nibble.
- frame_data  input  24  data nibbles; nibble 0 = [23:20], sent first; only the top NUM_DATA_NIBBLES nibbles are used.
- pulse_done  input  1  one-tick strobe from the pulse generator: current pulse complete.
- data_nibble  output  4  nibble value for the current pulse.
- sync  output  1  command: sync pulse.
- pulse  output  1  command: nibble pulse (status, data, CRC).
- pause  output  1  command: pause pulse.
- idle  output  1  command: idle line.
- frame_done  output  1  one-tick strobe after the last pulse of a frame.
- busy  output  1  a frame is in transmission (state != IDLE).

Behaviour:
- Reset (reset_tx==0 at an edge): state IDLE, buffer empty. Outputs: frame_ready=1, idle=1, sync=pulse=pause=0, data_nibble=0, frame_done=0, busy=0. Reset mid-frame aborts immediately; no partial pulse is completed.
- Exactly one of sync/pulse/pause/idle is high at any time. All outputs are registered.
- Holding buffer (status+data, 28 bits):
  - Loads on handshake; frame_ready = buffer empty.
  - A handshake in the same tick the buffer is consumed is legal: the buffer stays full with the new frame.
- States: IDLE, SYNC, STATUS, DATA, CRC, PAUSE.
- IDLE -> SYNC when the buffer is full:
  - Buffer moves into the working register and empties.
  - CRC accumulator set to CRC_SEED; nibble index set to 0.
  - Next tick: sync=1, idle=0, data_nibble=0.
  - Latency: handshake at edge N -> sync high after edge N+1.
- Advance happens on every edge with pulse_done==1. New command and data_nibble are visible from the following tick. pulse_done in IDLE is ignored.
  - SYNC -> STATUS: pulse=1, data_nibble=status.
  - STATUS -> DATA: data_nibble = nibble 0.
  - DATA: crc = nib XOR T(crc), where T(c) = c·x^4 mod (x^4+x^3+x^2+1).
    - If index < NUM_DATA_NIBBLES-1: index+1, output next nibble.
    - Else -> CRC, data_nibble = T(updated crc), i.e. augmented with a zero nibble.
  - Status nibble is excluded from the CRC.
  - CRC -> PAUSE (macro defined) or end-of-frame.
  - PAUSE -> end-of-frame.
- End-of-frame:
  - frame_done=1 for one tick.
  - If the buffer is full: go directly to SYNC (same load actions as above), with no idle tick.
  - Else: IDLE, idle=1, data_nibble=0.
- T table (index 0..15): 0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5.
- frame_valid while the buffer is full is held off; the frame is not lost, and the upstream holds frame_valid.

Optional Feature:
- SENT_TX_PAUSE_EN defined: a PAUSE state follows CRC. pause=1 and data_nibble=0 until pulse_done, then end-of-frame.
- Not defined: CRC pulse_done goes directly to end-of-frame. The `pause` port still exists and is tied 0.

Test Plan:
- Reset: hold reset_tx=0 for 3 ticks -> idle=1, frame_ready=1, busy=0, frame_done=0, all other commands 0.
- Single frame, status=4'h0, data=24'h000000, no pause. Bench model answers each command with pulse_done after 56 (sync) or 12+nibble ticks -> sequence sync, pulse 0, six pulses 0, CRC pulse data_nibble=5, then frame_done, then idle.
- status=4'hA, data=24'h123456 -> status pulse shows A, data pulses show 1..6, CRC nibble=2.
- Back-to-back: second frame offered during first frame's DATA state -> accepted immediately (frame_ready drops). After first frame_done, sync=1 on the next tick with no idle; frame_ready returns to 1.
- SENT_TX_PAUSE_EN defined -> after CRC pulse_done, pause=1. frame_done occurs only after the pause pulse_done.
- Reset asserted during DATA nibble 3 -> next tick idle=1, busy=0, buffer empty; a following frame starts cleanly with CRC seed 5.
